// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative decryptor.
// Contents: controller state enum, forward/inverse S-box tables, Rcon constants,
// GF(2^8) multiply helpers (xtime, x9, x11, x13, x14) and the one-step key schedule.
// Byte 0 of every 128-bit value is bits [127:120]; bytes run column-major.
package aes_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StKeyExp,
    StRound
  } aes_state_e;

  localparam logic [7:0] Sbox [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] InvSbox [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  localparam logic [7:0] Rcon [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] x9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] x11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] x13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] x14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Derives round key i from round key i-1; rcon is Rcon[i-1].
  function automatic logic [127:0] next_round_key(input logic [127:0] prev,
                                                  input logic [7:0]   rcon);
    logic [31:0] t;
    logic [31:0] w0, w1, w2, w3;
    // RotWord then SubWord of the last word
    t  = {Sbox[prev[23:16]], Sbox[prev[15:8]], Sbox[prev[7:0]], Sbox[prev[31:24]]};
    w0 = prev[127:96] ^ t ^ {rcon, 24'h0};
    w1 = prev[95:64] ^ w0;
    w2 = prev[63:32] ^ w1;
    w3 = prev[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_dec_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns
// unless last_i is set (round 0).
// Ports: state_i (round input), round_key_i (key for this round), last_i (skip
// InvMixColumns), state_o (round output). Purely combinational.
module aes_dec_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] round_key_i,
  input  logic         last_i,
  output logic [127:0] state_o
);

  logic [127:0] sub_shift;
  logic [127:0] ark;
  logic [127:0] mix;

  // Row r of the output takes column (c - r) mod 4 of the input.
  always_comb begin
    sub_shift = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub_shift[127 - 8*(r + 4*c) -: 8] =
            InvSbox[state_i[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8]];
      end
    end
  end

  assign ark = sub_shift ^ round_key_i;

  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    mix = '0;
    a0  = '0;
    a1  = '0;
    a2  = '0;
    a3  = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = ark[127 - 32*c -: 8];
      a1 = ark[119 - 32*c -: 8];
      a2 = ark[111 - 32*c -: 8];
      a3 = ark[103 - 32*c -: 8];
      mix[127 - 32*c -: 32] = {x14(a0) ^ x11(a1) ^ x13(a2) ^ x9(a3),
                               x9(a0)  ^ x14(a1) ^ x11(a2) ^ x13(a3),
                               x13(a0) ^ x9(a1)  ^ x14(a2) ^ x11(a3),
                               x11(a0) ^ x13(a1) ^ x9(a2)  ^ x14(a3)};
    end
  end

  assign state_o = last_i ? ark : mix;

endmodule

// File: rtl/aes_dec_iter.sv
// Iterative AES-128 decryptor with a resident expanded key.
// A key load expands rk1..rk10 one per cycle (10 cycles); each block then takes
// 10/ROUNDS_PER_CYCLE cycles, ROUNDS_PER_CYCLE inverse rounds per cycle (1, 2 or 5).
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   key_valid/key_ready/key_in       128-bit key load handshake
//   in_valid/in_ready/CipherText     ciphertext block handshake
//   out_valid/out_ready/PlainText    plaintext block handshake (held until taken)
//   key_ok                           an expanded key is resident
// Build option: define AES_DEC_CBC_EN to add iv_load/iv_in and CBC chaining;
// otherwise the block operates in ECB mode.
module aes_dec_iter
  import aes_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] CipherText,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] PlainText,
  output logic         key_ok
`ifdef AES_DEC_CBC_EN
  ,
  input  logic         iv_load,
  input  logic [127:0] iv_in
`endif
);

  localparam logic [3:0] RoundStep = 4'(ROUNDS_PER_CYCLE);

  aes_state_e   state_q, state_d;
  logic [3:0]   key_cnt_q, key_cnt_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] pt_q, pt_d;
  logic         out_valid_q, out_valid_d;
  logic         key_ok_q, key_ok_d;
  logic [127:0] rk_q [11];
  logic [127:0] rk_d [11];
  logic [127:0] chain_s [ROUNDS_PER_CYCLE + 1];

`ifdef AES_DEC_CBC_EN
  logic [127:0] cbc_q, cbc_d;
  logic [127:0] ct_q, ct_d;
`endif

  logic idle;
  logic key_fire;
  logic in_fire;
  logic out_fire;
  logic blk_block;

  assign idle      = (state_q == StIdle);
  assign key_ready = idle;
`ifdef AES_DEC_CBC_EN
  // An IV load in the same cycle wins over a block transfer.
  assign blk_block = key_valid | iv_load;
`else
  assign blk_block = key_valid;
`endif
  assign in_ready  = idle & key_ok_q & ~out_valid_q & ~blk_block;
  assign key_fire  = key_valid & key_ready;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid_q & out_ready;

  assign out_valid = out_valid_q;
  assign PlainText = pt_q;
  assign key_ok    = key_ok_q;

  // Stage g applies round (round_q - g); the chain output is the cycle's result.
  assign chain_s[0] = blk_q;
  for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
    logic [3:0] rnd;
    assign rnd = round_q - 4'(g);
    aes_dec_round u_round (
      .state_i     (chain_s[g]),
      .round_key_i (rk_q[rnd]),
      .last_i      (rnd == 4'd0),
      .state_o     (chain_s[g+1])
    );
  end

  always_comb begin
    state_d     = state_q;
    key_cnt_d   = key_cnt_q;
    round_d     = round_q;
    blk_d       = blk_q;
    pt_d        = pt_q;
    out_valid_d = out_valid_q;
    key_ok_d    = key_ok_q;
    rk_d        = rk_q;
`ifdef AES_DEC_CBC_EN
    cbc_d       = cbc_q;
    ct_d        = ct_q;
    if (idle && iv_load) begin
      cbc_d = iv_in;
    end
`endif

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (key_fire) begin
          rk_d[0]   = key_in;
          key_ok_d  = 1'b0;
          key_cnt_d = 4'd1;
          state_d   = StKeyExp;
        end else if (in_fire) begin
          blk_d   = CipherText ^ rk_q[10];
          round_d = 4'd9;
          state_d = StRound;
`ifdef AES_DEC_CBC_EN
          ct_d    = CipherText;
`endif
        end
      end

      StKeyExp: begin
        rk_d[key_cnt_q] = next_round_key(rk_q[key_cnt_q - 4'd1], Rcon[key_cnt_q - 4'd1]);
        key_cnt_d       = key_cnt_q + 4'd1;
        if (key_cnt_q == 4'd10) begin
          key_ok_d = 1'b1;
          state_d  = StIdle;
        end
      end

      StRound: begin
        blk_d   = chain_s[ROUNDS_PER_CYCLE];
        round_d = round_q - RoundStep;
        if (round_q == RoundStep - 4'd1) begin
`ifdef AES_DEC_CBC_EN
          pt_d  = chain_s[ROUNDS_PER_CYCLE] ^ cbc_q;
          cbc_d = ct_q;
`else
          pt_d  = chain_s[ROUNDS_PER_CYCLE];
`endif
          out_valid_d = 1'b1;
          // Park the index so idle-time key selects stay inside the file.
          round_d     = 4'd9;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      key_cnt_q   <= '0;
      round_q     <= 4'd9;
      blk_q       <= '0;
      pt_q        <= '0;
      out_valid_q <= 1'b0;
      key_ok_q    <= 1'b0;
      for (int i = 0; i < 11; i++) begin
        rk_q[i] <= '0;
      end
`ifdef AES_DEC_CBC_EN
      cbc_q       <= '0;
      ct_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      key_cnt_q   <= key_cnt_d;
      round_q     <= round_d;
      blk_q       <= blk_d;
      pt_q        <= pt_d;
      out_valid_q <= out_valid_d;
      key_ok_q    <= key_ok_d;
      rk_q        <= rk_d;
`ifdef AES_DEC_CBC_EN
      cbc_q       <= cbc_d;
      ct_q        <= ct_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_dec_iter.sv
// Self-checking bench for aes_dec_iter: one R=1 instance for handshake, reset and
// mode behaviour, plus R=2 and R=5 instances for latency. Expected plaintexts are
// queued when a block is accepted and popped when out_valid appears.
module tb_aes_dec_iter;

  localparam logic [127:0] KeyC   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CtC    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PtC    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KeyB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CtB    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PtB    = 128'h3243f6a8885a308d313198a2e0370734;
`ifdef AES_DEC_CBC_EN
  localparam logic [127:0] Iv     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CbcCt1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CbcPt1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CbcCt2 = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] CbcPt2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic key_valid, in_valid, out_ready;
  logic [127:0] key_in, ct;
  logic key_ready, in_ready, out_valid, key_ok;
  logic [127:0] pt;
`ifdef AES_DEC_CBC_EN
  logic iv_load;
  logic [127:0] iv_in;
`endif

  logic m_key_valid, m_in_valid;
  logic [127:0] m_key, m_ct;
  logic m2_key_ready, m2_in_ready, m2_out_valid, m2_key_ok;
  logic m5_key_ready, m5_in_ready, m5_out_valid, m5_key_ok;
  logic [127:0] m2_pt, m5_pt;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q [$];
  logic [127:0] model_chain;
  logic [127:0] last_exp;

  always #5 clk = ~clk;

  aes_dec_iter #(.ROUNDS_PER_CYCLE(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_in     (key_in),
    .key_ready  (key_ready),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .CipherText (ct),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .PlainText  (pt),
    .key_ok     (key_ok)
`ifdef AES_DEC_CBC_EN
    ,
    .iv_load    (iv_load),
    .iv_in      (iv_in)
`endif
  );

  aes_dec_iter #(.ROUNDS_PER_CYCLE(2)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (m_key_valid),
    .key_in     (m_key),
    .key_ready  (m2_key_ready),
    .in_valid   (m_in_valid),
    .in_ready   (m2_in_ready),
    .CipherText (m_ct),
    .out_valid  (m2_out_valid),
    .out_ready  (1'b1),
    .PlainText  (m2_pt),
    .key_ok     (m2_key_ok)
`ifdef AES_DEC_CBC_EN
    ,
    .iv_load    (1'b0),
    .iv_in      ('0)
`endif
  );

  aes_dec_iter #(.ROUNDS_PER_CYCLE(5)) dut5 (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (m_key_valid),
    .key_in     (m_key),
    .key_ready  (m5_key_ready),
    .in_valid   (m_in_valid),
    .in_ready   (m5_in_ready),
    .CipherText (m_ct),
    .out_valid  (m5_out_valid),
    .out_ready  (1'b1),
    .PlainText  (m5_pt),
    .key_ok     (m5_key_ok)
`ifdef AES_DEC_CBC_EN
    ,
    .iv_load    (1'b0),
    .iv_in      ('0)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    int n = 0;
    key_in    = k;
    key_valid = 1'b1;
    while (!key_ready && n < 40) begin
      tick();
      n++;
    end
    chk("key_ready_wait", key_ready, 1'b1);
    tick();
    key_valid = 1'b0;
  endtask

  // Called just after the key-transfer edge.
  task automatic wait_key_ok(input string tag);
    int n = 0;
    int bad = 0;
    while (!key_ok && n < 40) begin
      tick();
      n++;
      if (!key_ok && in_ready) bad++;
    end
    chk({tag, "_keyexp_cycles"}, n, 10);
    chk({tag, "_in_ready_in_keyexp"}, bad, 0);
  endtask

  task automatic send_raw(input logic [127:0] c, input logic [127:0] expv);
    int n = 0;
    ct       = c;
    in_valid = 1'b1;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    chk("in_ready_wait", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    exp_q.push_back(expv);
`ifdef AES_DEC_CBC_EN
    model_chain = c;
`endif
  endtask

  task automatic send_block(input logic [127:0] c, input logic [127:0] pt_ecb);
    send_raw(c, pt_ecb ^ model_chain);
  endtask

  // Called just after the block-transfer edge.
  task automatic wait_out(input string tag, input int lat);
    int n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, lat);
    if (exp_q.size() > 0) begin
      last_exp = exp_q.pop_front();
    end else begin
      last_exp = 'x;
      errors++;
      $display("FAIL %s_scoreboard: observed output with no expected entry", tag);
    end
    chk({tag, "_plaintext"}, pt, last_exp);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_out_drop"}, out_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat2, lat5, n;
    logic [127:0] p2, p5;

    rst_n = 1'b0;
    key_valid = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    key_in = '0;
    ct = '0;
    m_key_valid = 1'b0;
    m_in_valid = 1'b0;
    m_key = '0;
    m_ct = '0;
    model_chain = '0;
    last_exp = '0;
`ifdef AES_DEC_CBC_EN
    iv_load = 1'b0;
    iv_in = '0;
`endif
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_key_ready", key_ready, 1'b1);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_key_ok", key_ok, 1'b0);
    chk("rst_plaintext", pt, '0);

    // Latency for R=2 and R=5
    m_key = KeyB;
    m_key_valid = 1'b1;
    tick();
    m_key_valid = 1'b0;
    repeat (9) tick();
    chk("r2_key_ok_early", m2_key_ok, 1'b0);
    chk("r5_key_ok_early", m5_key_ok, 1'b0);
    tick();
    chk("r2_key_ok", m2_key_ok, 1'b1);
    chk("r5_key_ok", m5_key_ok, 1'b1);
    m_ct = CtB;
    chk("r2_in_ready", m2_in_ready, 1'b1);
    chk("r5_in_ready", m5_in_ready, 1'b1);
    m_in_valid = 1'b1;
    tick();
    m_in_valid = 1'b0;
    lat2 = -1;
    lat5 = -1;
    p2 = '0;
    p5 = '0;
    n = 0;
    while (n < 20 && (lat2 < 0 || lat5 < 0)) begin
      tick();
      n++;
      if (m2_out_valid && lat2 < 0) begin
        lat2 = n;
        p2 = m2_pt;
      end
      if (m5_out_valid && lat5 < 0) begin
        lat5 = n;
        p5 = m5_pt;
      end
    end
    chk("r2_latency", lat2, 5);
    chk("r5_latency", lat5, 2);
    chk("r2_plaintext", p2, PtB);
    chk("r5_plaintext", p5, PtB);

    // Block before any key waits; key wins over a simultaneous block
    ct = CtC;
    in_valid = 1'b1;
    repeat (3) begin
      tick();
      chk("nokey_in_ready", in_ready, 1'b0);
    end
    key_in = KeyC;
    key_valid = 1'b1;
    chk("both_key_ready", key_ready, 1'b1);
    chk("both_in_ready", in_ready, 1'b0);
    tick();
    key_valid = 1'b0;
    chk("both_keyexp_key_ready", key_ready, 1'b0);
    chk("both_keyexp_key_ok", key_ok, 1'b0);
    wait_key_ok("kc");
    send_block(CtC, PtC);
    wait_out("c1", 10);

    // Output back-pressure: second block held off
    ct = CtC;
    in_valid = 1'b1;
    repeat (5) begin
      tick();
      chk("hold_plaintext", pt, last_exp);
      chk("hold_out_valid", out_valid, 1'b1);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    consume("c1");
    chk("after_take_in_ready", in_ready, 1'b1);
    send_block(CtC, PtC);
    wait_out("c2", 10);

    // Key load while a result is pending
    load_key(KeyB);
    chk("kb_pending_pt", pt, last_exp);
    chk("kb_pending_valid", out_valid, 1'b1);
    chk("kb_key_ok_cleared", key_ok, 1'b0);
    wait_key_ok("kb");
    chk("kb_pending_pt_after", pt, last_exp);
    consume("c2");
    send_block(CtB, PtB);
    wait_out("b1", 10);
    consume("b1");

    // Reset in the middle of a block
    send_block(CtB, PtB);
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_key_ok", key_ok, 1'b0);
    chk("midrst_key_ready", key_ready, 1'b1);
    chk("midrst_plaintext", pt, '0);
    exp_q.delete();
    model_chain = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ct = CtB;
    in_valid = 1'b1;
    repeat (3) begin
      tick();
      chk("postrst_in_ready", in_ready, 1'b0);
    end
    load_key(KeyB);
    wait_key_ok("kr");
    send_block(CtB, PtB);
    wait_out("b2", 10);
    consume("b2");

`ifdef AES_DEC_CBC_EN
    // CBC chaining with an IV load that beats a block offer
    iv_in = Iv;
    iv_load = 1'b1;
    ct = CbcCt1;
    in_valid = 1'b1;
    chk("iv_in_ready", in_ready, 1'b0);
    tick();
    iv_load = 1'b0;
    in_valid = 1'b0;
    model_chain = Iv;
    send_raw(CbcCt1, CbcPt1);
    wait_out("cbc1", 10);
    consume("cbc1");
    send_raw(CbcCt2, CbcPt2);
    wait_out("cbc2", 10);
    consume("cbc2");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
